enemy_proj_handler: RTL and testbench

//  Downward-travelling counterpart of the player projectile handler: owns up to 3 enemy

---
 rtl/enemy_proj_handler.sv | 150 +++++++++++++++
 tb/tb_enemy_proj_handler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_proj_handler.sv
// enemy_proj_handler: three downward-travelling enemy projectile slots.
// Spawns from the shooter on an LFSR-gated, cooldown-limited schedule,
// retires projectiles at the bottom edge and reports hits on the player.
// A slot holding (0,0) is empty.
module enemy_proj_handler #(
  parameter int          BOTTOM_BOUNDARY = 470,
  parameter int          STEP            = 1,
  parameter int          PROJ_H          = 8,
  parameter int          COOLDOWN        = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [15:0] FIRE_MASK       = 16'h000F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_projSpeed,
  input  logic       fireEnable,
  input  logic       shooterValid,
  input  logic [9:0] shooterX,
  input  logic [8:0] shooterY,
  input  logic [9:0] playerX,
  input  logic [8:0] playerY,
  input  logic [9:0] playerW,
  output logic [9:0] o_eproj1X,
  output logic [9:0] o_eproj2X,
  output logic [9:0] o_eproj3X,
  output logic [8:0] o_eproj1Y,
  output logic [8:0] o_eproj2Y,
  output logic [8:0] o_eproj3Y,
  output logic       playerHit,
  output logic [1:0] hitSlot,
  output logic [1:0] activeCount
);

  localparam int          CD_W     = $clog2(COOLDOWN + 1);
  localparam logic [9:0]  BOTTOM_V = 10'(BOTTOM_BOUNDARY);
  localparam logic [9:0]  STEP_V   = 10'(STEP);
  localparam logic [10:0] PROJ_H_V = 11'(PROJ_H);

  logic [9:0]      slotX [3];
  logic [8:0]      slotY [3];
  logic [9:0]      nextX [3];
  logic [8:0]      nextY [3];
  logic [9:0]      movedY [3];
  logic [15:0]     lfsr, lfsrNext;
  logic [CD_W-1:0] cooldown, cooldownNext;
  logic [2:0]      active, hitVec, hitOne, emptyVec, spawnOne;
  logic [9:0]      spawnY;
  logic            spawnOk;
  logic [1:0]      hitSlotNext;
  logic [1:0]      countNext;

  assign o_eproj1X = slotX[0];
  assign o_eproj2X = slotX[1];
  assign o_eproj3X = slotX[2];
  assign o_eproj1Y = slotY[0];
  assign o_eproj2Y = slotY[1];
  assign o_eproj3Y = slotY[2];

  // Occupancy and player-overlap test on the registered slots, using 11-bit sums.
  always_comb begin
    active = '0;
    hitVec = '0;
    for (int i = 0; i < 3; i++) begin
      active[i] = (slotX[i] != 10'd0) || (slotY[i] != 9'd0);
      hitVec[i] = active[i]
                && ({1'b0, slotX[i]} >= {1'b0, playerX})
                && ({1'b0, slotX[i]} <  ({1'b0, playerX} + {1'b0, playerW}))
                && (({2'b0, slotY[i]} + PROJ_H_V) > {2'b0, playerY})
                && ({2'b0, slotY[i]} <  ({2'b0, playerY} + {1'b0, playerW}));
    end
  end

  // Pick the lowest hitting slot and the lowest empty slot, and decide whether to spawn.
  // A slot being cleared by a hit is active now, so it is never counted as empty.
  always_comb begin
    hitOne   = hitVec & (~hitVec + 3'd1);
    emptyVec = ~active;
    spawnOne = emptyVec & (~emptyVec + 3'd1);
    spawnY   = {1'b0, shooterY} + 10'd1;
    spawnOk  = pulse_projSpeed && fireEnable && shooterValid
            && (cooldown == '0) && ((lfsr & FIRE_MASK) == 16'd0)
            && (|emptyVec) && (spawnY < BOTTOM_V);
    hitSlotNext = hitOne[0] ? 2'b01 :
                  hitOne[1] ? 2'b10 :
                  hitOne[2] ? 2'b11 : 2'b00;
    countNext = {1'b0, active[0]} + {1'b0, active[1]} + {1'b0, active[2]};
  end

  // Per-slot next state: hit clear wins over spawn, spawn wins over movement.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nextX[i]  = slotX[i];
      nextY[i]  = slotY[i];
      movedY[i] = {1'b0, slotY[i]} + STEP_V;
      if (hitOne[i]) begin
        nextX[i] = 10'd0;
        nextY[i] = 9'd0;
      end else if (spawnOk && spawnOne[i]) begin
        nextX[i] = shooterX;
        nextY[i] = spawnY[8:0];
      end else if (pulse_projSpeed && active[i]) begin
        if (movedY[i] >= BOTTOM_V) begin
          nextX[i] = 10'd0;
          nextY[i] = 9'd0;
        end else begin
          nextY[i] = movedY[i][8:0];
        end
      end
    end
  end

  // Fire LFSR (taps 16,14,13,11) and spawn cooldown, both stepped by the movement tick.
  always_comb begin
    lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (spawnOk)
      cooldownNext = CD_W'(COOLDOWN);
    else if (cooldown != '0)
      cooldownNext = cooldown - 1'b1;
    else
      cooldownNext = '0;
  end

  // State register; reset empties every slot and cancels any pending hit report.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        slotX[i] <= 10'd0;
        slotY[i] <= 9'd0;
      end
      lfsr        <= LFSR_SEED;
      cooldown    <= '0;
      playerHit   <= 1'b0;
      hitSlot     <= 2'b00;
      activeCount <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        slotX[i] <= nextX[i];
        slotY[i] <= nextY[i];
      end
      if (pulse_projSpeed) begin
        lfsr     <= lfsrNext;
        cooldown <= cooldownNext;
      end
      playerHit   <= |hitVec;
      hitSlot     <= hitSlotNext;
      activeCount <= countNext;
    end
  end

endmodule

// File: tb/tb_enemy_proj_handler.sv
// tb_enemy_proj_handler: scoreboard bench for enemy_proj_handler.
// A behavioural model predicts every registered output per clock; predictions are
// queued when stimulus is driven and compared after the edge. Scenario tasks add
// directed checks against fixed values.
module tb_enemy_proj_handler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_projSpeed = 1'b0;
  logic       fireEnable = 1'b0;
  logic       shooterValid = 1'b0;
  logic [9:0] shooterX = 10'd0;
  logic [8:0] shooterY = 9'd0;
  logic [9:0] playerX = 10'd0;
  logic [8:0] playerY = 9'd0;
  logic [9:0] playerW = 10'd0;
  logic [9:0] o_eproj1X, o_eproj2X, o_eproj3X;
  logic [8:0] o_eproj1Y, o_eproj2Y, o_eproj3Y;
  logic       playerHit;
  logic [1:0] hitSlot;
  logic [1:0] activeCount;

  typedef struct packed {
    logic [9:0] x0, x1, x2;
    logic [8:0] y0, y1, y2;
    logic       hit;
    logic [1:0] hs;
    logic [1:0] cnt;
  } snap_t;

  snap_t sb[$];
  int testsRun = 0;
  int testsFailed = 0;
  int mX[3];
  int mY[3];
  int mL = 'hACE1;
  int mCd = 0;

  enemy_proj_handler dut (
    .clk(clk), .rst(rst), .pulse_projSpeed(pulse_projSpeed),
    .fireEnable(fireEnable), .shooterValid(shooterValid),
    .shooterX(shooterX), .shooterY(shooterY),
    .playerX(playerX), .playerY(playerY), .playerW(playerW),
    .o_eproj1X(o_eproj1X), .o_eproj2X(o_eproj2X), .o_eproj3X(o_eproj3X),
    .o_eproj1Y(o_eproj1Y), .o_eproj2Y(o_eproj2Y), .o_eproj3Y(o_eproj3Y),
    .playerHit(playerHit), .hitSlot(hitSlot), .activeCount(activeCount)
  );

  always #5 clk = ~clk;

  // One clock: predict the post-edge outputs from the current inputs, queue them,
  // let the edge happen, then pop the prediction and compare at the falling edge.
  task automatic applyStimulus();
    snap_t e, g;
    int act[3];
    int nX[3];
    int nY[3];
    int hitI, emptyI, cnt, fb;
    bit spawn;
    e = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin mX[i] = 0; mY[i] = 0; end
      mL = 'hACE1;
      mCd = 0;
    end else begin
      cnt = 0; hitI = -1; emptyI = -1;
      for (int i = 0; i < 3; i++) begin
        act[i] = (mX[i] != 0 || mY[i] != 0) ? 1 : 0;
        cnt += act[i];
        if (act[i] == 1 && hitI < 0 && mX[i] >= playerX && mX[i] < playerX + playerW
            && mY[i] + 8 > playerY && mY[i] < playerY + playerW) hitI = i;
        if (act[i] == 0 && emptyI < 0) emptyI = i;
      end
      spawn = pulse_projSpeed && fireEnable && shooterValid && mCd == 0
           && (mL & 'hF) == 0 && emptyI >= 0 && (shooterY + 1) < 470;
      for (int i = 0; i < 3; i++) begin
        nX[i] = mX[i]; nY[i] = mY[i];
        if (i == hitI) begin
          nX[i] = 0; nY[i] = 0;
        end else if (spawn && i == emptyI) begin
          nX[i] = shooterX; nY[i] = shooterY + 1;
        end else if (pulse_projSpeed && act[i] == 1) begin
          if (mY[i] + 1 >= 470) begin nX[i] = 0; nY[i] = 0; end
          else nY[i] = mY[i] + 1;
        end
      end
      if (pulse_projSpeed) begin
        fb  = ((mL >> 15) ^ (mL >> 13) ^ (mL >> 12) ^ (mL >> 10)) & 1;
        mL  = ((mL << 1) | fb) & 'hFFFF;
        mCd = spawn ? 60 : (mCd > 0 ? mCd - 1 : 0);
      end
      for (int i = 0; i < 3; i++) begin mX[i] = nX[i]; mY[i] = nY[i]; end
      e.hit = (hitI >= 0);
      e.hs  = 2'(hitI + 1);
      e.cnt = 2'(cnt);
    end
    e.x0 = 10'(mX[0]); e.x1 = 10'(mX[1]); e.x2 = 10'(mX[2]);
    e.y0 = 9'(mY[0]);  e.y1 = 9'(mY[1]);  e.y2 = 9'(mY[2]);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    g = '{o_eproj1X, o_eproj2X, o_eproj3X, o_eproj1Y, o_eproj2Y, o_eproj3Y,
          playerHit, hitSlot, activeCount};
    testsRun++;
    if (g !== e) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard t=%0t got X=%0d,%0d,%0d Y=%0d,%0d,%0d hit=%0b slot=%0d cnt=%0d want X=%0d,%0d,%0d Y=%0d,%0d,%0d hit=%0b slot=%0d cnt=%0d",
               $time, g.x0, g.x1, g.x2, g.y0, g.y1, g.y2, g.hit, g.hs, g.cnt,
               e.x0, e.x1, e.x2, e.y0, e.y1, e.y2, e.hit, e.hs, e.cnt);
    end
  endtask

  // Synchronous reset with every control input parked idle.
  task automatic doReset();
    pulse_projSpeed = 0; fireEnable = 0; shooterValid = 0; playerW = 0;
    rst = 1;
    applyStimulus();
    rst = 0;
  endtask

  // Tick with firing disabled until the next tick would fire, then fire from (x,y).
  task automatic spawnAt(input int x, input int y);
    int guard = 0;
    fireEnable = 0;
    pulse_projSpeed = 1;
    while (!(mCd == 0 && (mL & 'hF) == 0) && guard < 3000) begin
      applyStimulus();
      guard++;
    end
    testsRun++;
    if (guard >= 3000) begin
      testsFailed++;
      $display("[TB] FAIL spawn_wait got %0d ticks want fewer than 3000", guard);
    end
    fireEnable = 1; shooterValid = 1;
    shooterX = 10'(x); shooterY = 9'(y);
    applyStimulus();
    fireEnable = 0;
    pulse_projSpeed = 0;
  endtask

  // Reset clears all outputs.
  task automatic test_reset();
    rst = 1;
    applyStimulus();
    applyStimulus();
    testsRun++;
    if ({o_eproj1X, o_eproj2X, o_eproj3X} !== 30'd0 || {o_eproj1Y, o_eproj2Y, o_eproj3Y} !== 27'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_slots got X=%0d,%0d,%0d Y=%0d,%0d,%0d want all 0",
               o_eproj1X, o_eproj2X, o_eproj3X, o_eproj1Y, o_eproj2Y, o_eproj3Y);
    end
    testsRun++;
    if (playerHit !== 1'b0 || hitSlot !== 2'b00 || activeCount !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags got hit=%0b slot=%0d cnt=%0d want 0,0,0", playerHit, hitSlot, activeCount);
    end
    rst = 0;
  endtask

  // First spawn lands in slot1 one pixel below the shooter, then the cooldown holds.
  task automatic test_spawn_cooldown();
    doReset();
    spawnAt(100, 50);
    testsRun++;
    if (o_eproj1X !== 10'd100 || o_eproj1Y !== 9'd51) begin
      testsFailed++;
      $display("[TB] FAIL first_spawn got (%0d,%0d) want (100,51)", o_eproj1X, o_eproj1Y);
    end
    testsRun++;
    if (activeCount !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL count_lag got %0d want 0", activeCount);
    end
    applyStimulus();
    testsRun++;
    if (activeCount !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL count_after_spawn got %0d want 1", activeCount);
    end
    fireEnable = 1; shooterValid = 1; shooterX = 10'd300; shooterY = 9'd20;
    pulse_projSpeed = 1;
    for (int i = 0; i < 60; i++) applyStimulus();
    pulse_projSpeed = 0;
    testsRun++;
    if (o_eproj2X !== 10'd0 || o_eproj2Y !== 9'd0 || o_eproj1Y !== 9'd111) begin
      testsFailed++;
      $display("[TB] FAIL cooldown got slot2=(%0d,%0d) slot1Y=%0d want (0,0) 111", o_eproj2X, o_eproj2Y, o_eproj1Y);
    end
    fireEnable = 0;
  endtask

  // A projectile reaching the bottom boundary is retired without a hit.
  task automatic test_retire();
    doReset();
    spawnAt(50, 468);
    testsRun++;
    if (o_eproj1X !== 10'd50 || o_eproj1Y !== 9'd469) begin
      testsFailed++;
      $display("[TB] FAIL retire_setup got (%0d,%0d) want (50,469)", o_eproj1X, o_eproj1Y);
    end
    pulse_projSpeed = 1;
    applyStimulus();
    pulse_projSpeed = 0;
    testsRun++;
    if (o_eproj1X !== 10'd0 || o_eproj1Y !== 9'd0 || playerHit !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL retire got (%0d,%0d) hit=%0b want (0,0) 0", o_eproj1X, o_eproj1Y, playerHit);
    end
  endtask

  // Slot2 overlapping the player is cleared and reported for exactly one cycle.
  task automatic test_hit();
    doReset();
    spawnAt(300, 0);
    spawnAt(100, 392);
    testsRun++;
    if (o_eproj2X !== 10'd100 || o_eproj2Y !== 9'd393) begin
      testsFailed++;
      $display("[TB] FAIL hit_setup got (%0d,%0d) want (100,393)", o_eproj2X, o_eproj2Y);
    end
    playerX = 10'd96; playerY = 9'd400; playerW = 10'd16;
    applyStimulus();
    testsRun++;
    if (o_eproj2X !== 10'd0 || o_eproj2Y !== 9'd0 || playerHit !== 1'b1 || hitSlot !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL hit_slot2 got (%0d,%0d) hit=%0b slot=%0d want (0,0) 1 2", o_eproj2X, o_eproj2Y, playerHit, hitSlot);
    end
    applyStimulus();
    testsRun++;
    if (playerHit !== 1'b0 || hitSlot !== 2'b00 || o_eproj1X !== 10'd300) begin
      testsFailed++;
      $display("[TB] FAIL hit_pulse_end got hit=%0b slot=%0d slot1X=%0d want 0 0 300", playerHit, hitSlot, o_eproj1X);
    end
    playerW = 10'd0;
  endtask

  // Full slots block spawning without reloading the cooldown.
  task automatic test_slots_full();
    int guard = 0;
    doReset();
    spawnAt(100, 0);
    spawnAt(300, 0);
    spawnAt(500, 0);
    applyStimulus();
    testsRun++;
    if (activeCount !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL full_count got %0d want 3", activeCount);
    end
    fireEnable = 1; shooterValid = 1; shooterX = 10'd700; shooterY = 9'd0;
    pulse_projSpeed = 1;
    while (!(mCd == 0 && (mL & 'hF) == 0) && guard < 3000) begin applyStimulus(); guard++; end
    applyStimulus();
    testsRun++;
    if (guard >= 3000 || o_eproj1X !== 10'd100 || o_eproj2X !== 10'd300 || o_eproj3X !== 10'd500 || activeCount !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL full_blocked got X=%0d,%0d,%0d cnt=%0d wait=%0d want 100,300,500 3", o_eproj1X, o_eproj2X, o_eproj3X, activeCount, guard);
    end
    pulse_projSpeed = 0;
    playerX = 10'd290; playerY = 9'(mY[1]); playerW = 10'd20;
    applyStimulus();
    playerW = 10'd0;
    testsRun++;
    if (o_eproj2X !== 10'd0 || hitSlot !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL full_free got slot2X=%0d slot=%0d want 0 2", o_eproj2X, hitSlot);
    end
    pulse_projSpeed = 1;
    guard = 0;
    while ((mL & 'hF) != 0 && guard < 3000) begin applyStimulus(); guard++; end
    applyStimulus();
    pulse_projSpeed = 0;
    testsRun++;
    if (guard >= 3000 || o_eproj2X !== 10'd700 || o_eproj2Y !== 9'd1) begin
      testsFailed++;
      $display("[TB] FAIL full_respawn got (%0d,%0d) wait=%0d want (700,1)", o_eproj2X, o_eproj2Y, guard);
    end
    fireEnable = 0;
  endtask

  // Back-to-back hits on slots 1 and 3, the first coinciding with a movement tick.
  task automatic test_back_to_back();
    int y2;
    doReset();
    spawnAt(200, 0);
    spawnAt(800, 0);
    spawnAt(200, 0);
    y2 = mY[1];
    playerX = 10'd190; playerY = 9'd0; playerW = 10'd480;
    pulse_projSpeed = 1;
    applyStimulus();
    pulse_projSpeed = 0;
    testsRun++;
    if (o_eproj1X !== 10'd0 || hitSlot !== 2'b01 || playerHit !== 1'b1 || o_eproj3X !== 10'd200 || int'(o_eproj2Y) != y2 + 1) begin
      testsFailed++;
      $display("[TB] FAIL double_first got slot1X=%0d hit=%0b slot=%0d slot3X=%0d slot2Y=%0d want 0 1 1 200 %0d",
               o_eproj1X, playerHit, hitSlot, o_eproj3X, o_eproj2Y, y2 + 1);
    end
    applyStimulus();
    testsRun++;
    if (o_eproj3X !== 10'd0 || hitSlot !== 2'b11 || playerHit !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL double_second got slot3X=%0d hit=%0b slot=%0d want 0 1 3", o_eproj3X, playerHit, hitSlot);
    end
    applyStimulus();
    testsRun++;
    if (playerHit !== 1'b0 || hitSlot !== 2'b00 || o_eproj2X !== 10'd800) begin
      testsFailed++;
      $display("[TB] FAIL double_end got hit=%0b slot=%0d slot2X=%0d want 0 0 800", playerHit, hitSlot, o_eproj2X);
    end
    playerW = 10'd0;
  endtask

  // Reset with three live slots and a pending hit suppresses the hit report.
  task automatic test_reset_midflight();
    doReset();
    spawnAt(100, 0);
    spawnAt(300, 0);
    spawnAt(500, 0);
    playerX = 10'd90; playerY = 9'd0; playerW = 10'd400;
    rst = 1;
    applyStimulus();
    rst = 0;
    testsRun++;
    if ({o_eproj1X, o_eproj2X, o_eproj3X} !== 30'd0 || {o_eproj1Y, o_eproj2Y, o_eproj3Y} !== 27'd0
        || playerHit !== 1'b0 || activeCount !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL midflight_reset got X=%0d,%0d,%0d hit=%0b cnt=%0d want 0,0,0 0 0",
               o_eproj1X, o_eproj2X, o_eproj3X, playerHit, activeCount);
    end
    applyStimulus();
    testsRun++;
    if (playerHit !== 1'b0 || hitSlot !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL midflight_nohit got hit=%0b slot=%0d want 0 0", playerHit, hitSlot);
    end
    playerW = 10'd0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_spawn_cooldown();
    test_retire();
    test_hit();
    test_slots_full();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
